punc_controller: RTL and testbench
==================================

PUNC_CONTROLLER -- requirements
Module: punc_controller

Interface
REQ-001 Parameter INIT_NZP, default 3'b010, condition-code value loaded at reset.
REQ-002 Parameter HALT_OPCODE, default 4'b1111, opcode[15:12] value that enters HALT.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 opcode  input  16  current IR contents from the datapath.
REQ-006 condCode  input  3  datapath {N,Z,P} of the current RF write data.
REQ-007 load_ir, inc_pc, mem_w_en, rf_w_en  output  1 each  one-cycle strobes.
REQ-008 set_pc  output  3  program-counter select:
  - 0 hold
  - 1 PC+off9
  - 2 PC+off11
  - 3 RF read port 0
REQ-009 alu_select  output  3  ALU operation:
  - 0 ADD reg
  - 1 ADD imm5
  - 2 AND reg
  - 3 AND imm5
  - 4 PC+off9
  - 5 NOT
REQ-010 set_mem_r_addr  output  3  memory read-address select:
  - 0 PC (fetch)
  - 1 PC+off9
  - 2 indirect
  - 3 RF+off6
REQ-011 set_mem_w_addr  output  2  memory write-address select:
  - 0 PC+off9
  - 1 mem read data
  - 2 RF port 1+off6
REQ-012 set_mem_w_data  output  1  constant 0 (store data from RF port 0).
REQ-013 set_rf_r_addr0  output  2  RF read port 0 address: 0 ir[8:6], 1 ir[11:9], 2 R7.
REQ-014 set_rf_r_addr1  output  2  RF read port 1 address: 0 ir[2:0], 1 ir[8:6].
REQ-015 set_rf_w_addr  output  2  RF write address: 0 ir[11:9], 1 R7.
REQ-016 set_rf_w_data  output  2  RF write data: 0 ALU, 1 PC, 2 mem.
REQ-017 nzp  output  3  architectural condition-code register.
REQ-018 halted  output  1  high while in HALT.
REQ-019 state_dbg  output  3  encoding:
  - 0 FETCH
  - 1 DECODE
  - 2 EXEC
  - 3 EXEC2
  - 4 HALT

Function
REQ-020 FSM cycle: FETCH -> DECODE -> EXEC -> FETCH. LDI and STI insert EXEC2 between EXEC and FETCH. HALT_OPCODE goes DECODE -> HALT.
REQ-021 FETCH: set_mem_r_addr=0, load_ir=1.
REQ-022 DECODE: inc_pc=1. The IR (opcode) is stable from DECODE onward.
REQ-023 Outputs are combinational from state and opcode[15:12]. Every strobe and select is 0 unless this section requires otherwise.
REQ-024 EXEC for ADD/AND:
  - rf_w_en=1, set_rf_w_addr=0, set_rf_w_data=0, set_rf_r_addr0=0, set_rf_r_addr1=0.
  - alu_select = ir[5] ? imm : reg.
REQ-025 EXEC for NOT: alu_select=5, rf_w_en=1. LEA: alu_select=4, rf_w_en=1.
REQ-026 EXEC for LD: set_mem_r_addr=1, set_rf_w_data=2, rf_w_en=1. LDR: the same but set_mem_r_addr=3, set_rf_r_addr0=0.
REQ-027 EXEC for ST: mem_w_en=1, set_mem_w_addr=0, set_rf_r_addr0=1. STR: the same but set_mem_w_addr=2, set_rf_r_addr1=1.
REQ-028 LDI:
  - EXEC: set_mem_r_addr=1 (pointer capture).
  - EXEC2: set_mem_r_addr=2, set_rf_w_data=2, rf_w_en=1.
REQ-029 STI:
  - EXEC: set_mem_r_addr=1.
  - EXEC2: set_mem_r_addr=1, set_mem_w_addr=1, set_rf_r_addr0=1, mem_w_en=1.
REQ-030 JSR (ir[11]=1) and JSRR (ir[11]=0):
  - rf_w_en=1, set_rf_w_addr=1, set_rf_w_data=1.
  - set_pc=2 for JSR; set_pc=3 with set_rf_r_addr0=0 for JSRR.
REQ-031 JMP/RET: set_pc=3, set_rf_r_addr0=0 (RET is encoded as base R7).
REQ-032 BR: set_pc=1 exactly when (ir[11:9] & nzp) != 0; otherwise no output is asserted. BR with ir[11:9]=000 is never taken.
REQ-033 nzp is loaded from condCode at the EXEC/EXEC2 edge where rf_w_en=1 and the opcode is ADD, AND, NOT, LD, LDR, LDI or LEA. JSR/JSRR leave nzp unchanged.
REQ-034 Opcodes 1000 and 1101 are NOPs in EXEC; the FSM returns to FETCH.
REQ-035 HALT: every strobe is 0 and the FSM stays in HALT until rst.
REQ-036 Each instruction asserts at most one write strobe (mem_w_en or rf_w_en) in any cycle. The exception is JSR/JSRR, which asserts rf_w_en together with set_pc.

Reset
REQ-037 On a clock edge with rst=1: state <= FETCH, nzp <= INIT_NZP.
REQ-038 While rst=1, load_ir, inc_pc, mem_w_en, rf_w_en are 0 and set_pc=0, in any state.
REQ-039 rst asserted mid-instruction (including EXEC2 and HALT) abandons the instruction; no partial write occurs in that cycle.

Verification
REQ-040 Reset then opcode=16'h1042 (ADD R0,R1,R2), condCode=100: load_ir in cycle 0, inc_pc in cycle 1, rf_w_en with alu_select=0 in cycle 2, nzp=100 after cycle 2, state_dbg=0 in cycle 3.
REQ-041 opcode=16'h0402 (BRz) with nzp=010 -> set_pc=1 in EXEC. The same opcode with nzp=001 -> set_pc=0 and no strobes.
REQ-042 opcode=16'hA203 (LDI): 4-cycle instruction. EXEC has set_mem_r_addr=1 and rf_w_en=0; EXEC2 has set_mem_r_addr=2, rf_w_en=1, set_rf_w_data=2.
REQ-043 opcode=16'h4805 (JSR) with condCode=001 while nzp=010 -> rf_w_en=1, set_rf_w_addr=1, set_pc=2; nzp stays 010.
REQ-044 opcode=16'hF025 -> halted=1 from cycle 2 onward, with no strobes for 10 cycles. rst then gives FETCH with load_ir=1 on the following cycle.
REQ-045 rst pulsed during EXEC2 of STI -> mem_w_en=0 in that cycle, state_dbg=0 next, nzp=010.

Source files
------------

// File: rtl/punc_controller.sv
// Control FSM for a small LC-3 style core: sequences fetch/decode/execute and
// drives datapath selects and write strobes from the state and the IR opcode.
module punc_controller #(
   parameter logic [2:0] INIT_NZP    = 3'b010,
   parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] opcode,
   input  logic [2:0]  condCode,
   output logic        load_ir,
   output logic        inc_pc,
   output logic        mem_w_en,
   output logic        rf_w_en,
   output logic [2:0]  set_pc,
   output logic [2:0]  alu_select,
   output logic [2:0]  set_mem_r_addr,
   output logic [1:0]  set_mem_w_addr,
   output logic        set_mem_w_data,
   output logic [1:0]  set_rf_r_addr0,
   output logic [1:0]  set_rf_r_addr1,
   output logic [1:0]  set_rf_w_addr,
   output logic [1:0]  set_rf_w_data,
   output logic [2:0]  nzp,
   output logic        halted,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_EXEC2  = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   state_t     state, state_nxt;
   logic [3:0] op;
   logic       cc_op;
   logic       unused_ir_bits;

   assign op             = opcode[15:12];
   assign unused_ir_bits = ^{opcode[8:6], opcode[4:0]};

   // Only instructions that produce a register result update the condition codes.
   assign cc_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
                  (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI) ||
                  (op == OP_LEA);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         nzp   <= INIT_NZP;
      end else begin
         state <= state_nxt;
         if (rf_w_en && cc_op)
            nzp <= condCode;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: state_nxt = (op == HALT_OPCODE) ? S_HALT : S_EXEC;
         S_EXEC:   state_nxt = (op == OP_LDI || op == OP_STI) ? S_EXEC2 : S_FETCH;
         S_EXEC2:  state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      load_ir        = 1'b0;
      inc_pc         = 1'b0;
      mem_w_en       = 1'b0;
      rf_w_en        = 1'b0;
      set_pc         = 3'd0;
      alu_select     = 3'd0;
      set_mem_r_addr = 3'd0;
      set_mem_w_addr = 2'd0;
      set_mem_w_data = 1'b0;
      set_rf_r_addr0 = 2'd0;
      set_rf_r_addr1 = 2'd0;
      set_rf_w_addr  = 2'd0;
      set_rf_w_data  = 2'd0;
      case (state)
         S_FETCH:  load_ir = 1'b1;
         S_DECODE: inc_pc  = 1'b1;
         S_EXEC: begin
            case (op)
               OP_ADD: begin
                  rf_w_en    = 1'b1;
                  alu_select = opcode[5] ? 3'd1 : 3'd0;
               end
               OP_AND: begin
                  rf_w_en    = 1'b1;
                  alu_select = opcode[5] ? 3'd3 : 3'd2;
               end
               OP_NOT: begin
                  rf_w_en    = 1'b1;
                  alu_select = 3'd5;
               end
               OP_LEA: begin
                  rf_w_en    = 1'b1;
                  alu_select = 3'd4;
               end
               OP_LD: begin
                  rf_w_en        = 1'b1;
                  set_mem_r_addr = 3'd1;
                  set_rf_w_data  = 2'd2;
               end
               OP_LDR: begin
                  rf_w_en        = 1'b1;
                  set_mem_r_addr = 3'd3;
                  set_rf_w_data  = 2'd2;
               end
               OP_ST: begin
                  mem_w_en       = 1'b1;
                  set_rf_r_addr0 = 2'd1;
               end
               OP_STR: begin
                  mem_w_en       = 1'b1;
                  set_mem_w_addr = 2'd2;
                  set_rf_r_addr0 = 2'd1;
                  set_rf_r_addr1 = 2'd1;
               end
               // First half of the indirect ops: fetch the pointer word.
               OP_LDI, OP_STI: set_mem_r_addr = 3'd1;
               OP_JSR: begin
                  rf_w_en       = 1'b1;
                  set_rf_w_addr = 2'd1;
                  set_rf_w_data = 2'd1;
                  set_pc        = opcode[11] ? 3'd2 : 3'd3;
               end
               OP_JMP: set_pc = 3'd3;
               OP_BR:  set_pc = ((opcode[11:9] & nzp) != 3'b000) ? 3'd1 : 3'd0;
               default: ;
            endcase
         end
         S_EXEC2: begin
            if (op == OP_LDI) begin
               rf_w_en        = 1'b1;
               set_mem_r_addr = 3'd2;
               set_rf_w_data  = 2'd2;
            end else if (op == OP_STI) begin
               mem_w_en       = 1'b1;
               set_mem_r_addr = 3'd1;
               set_mem_w_addr = 2'd1;
               set_rf_r_addr0 = 2'd1;
            end
         end
         default: ;
      endcase
      // Reset kills any in-flight write or PC redirect regardless of state.
      if (rst) begin
         load_ir  = 1'b0;
         inc_pc   = 1'b0;
         mem_w_en = 1'b0;
         rf_w_en  = 1'b0;
         set_pc   = 3'd0;
      end
   end

   assign halted    = (state == S_HALT);
   assign state_dbg = state;

endmodule

// File: tb/tb_punc_controller.sv
// Directed bench for punc_controller: an instruction-level model predicts every
// cycle's outputs; a compare process checks them, plus literal spot checks.
module tb_punc_controller;

   typedef struct packed {
      logic       load_ir;
      logic       inc_pc;
      logic       mem_w_en;
      logic       rf_w_en;
      logic [2:0] set_pc;
      logic [2:0] alu_select;
      logic [2:0] mem_r;
      logic [1:0] mem_w_addr;
      logic       mem_w_data;
      logic [1:0] r0;
      logic [1:0] r1;
      logic [1:0] w_addr;
      logic [1:0] w_data;
      logic [2:0] nzp;
      logic       halted;
      logic [2:0] state;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] opcode = 16'h0000;
   logic [2:0]  condCode = 3'b000;
   logic        load_ir, inc_pc, mem_w_en, rf_w_en, set_mem_w_data, halted;
   logic [2:0]  set_pc, alu_select, set_mem_r_addr, nzp, state_dbg;
   logic [1:0]  set_mem_w_addr, set_rf_r_addr0, set_rf_r_addr1, set_rf_w_addr, set_rf_w_data;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   exp_t tmp_q[$];
   exp_t obs[0:15];
   exp_t act;
   logic [2:0] m_nzp = 3'b010;

   always #5 clk = ~clk;

   punc_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .condCode(condCode),
      .load_ir(load_ir), .inc_pc(inc_pc), .mem_w_en(mem_w_en), .rf_w_en(rf_w_en),
      .set_pc(set_pc), .alu_select(alu_select), .set_mem_r_addr(set_mem_r_addr),
      .set_mem_w_addr(set_mem_w_addr), .set_mem_w_data(set_mem_w_data),
      .set_rf_r_addr0(set_rf_r_addr0), .set_rf_r_addr1(set_rf_r_addr1),
      .set_rf_w_addr(set_rf_w_addr), .set_rf_w_data(set_rf_w_data),
      .nzp(nzp), .halted(halted), .state_dbg(state_dbg)
   );

   assign act = {load_ir, inc_pc, mem_w_en, rf_w_en, set_pc, alu_select, set_mem_r_addr,
                 set_mem_w_addr, set_mem_w_data, set_rf_r_addr0, set_rf_r_addr1,
                 set_rf_w_addr, set_rf_w_data, nzp, halted, state_dbg};

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("cycle_outputs", 64'(act), 64'(e));
      end
   end

   function automatic exp_t blank(input logic [2:0] st);
      exp_t e;
      e = '0;
      e.nzp = m_nzp;
      e.state = st;
      return e;
   endfunction

   // Instruction semantics: what every cycle of one instruction must look like.
   task automatic build(input logic [15:0] op, input logic [2:0] cc);
      exp_t e;
      logic [3:0] oc;
      oc = op[15:12];
      tmp_q.delete();
      e = blank(3'd0); e.load_ir = 1'b1; tmp_q.push_back(e);
      e = blank(3'd1); e.inc_pc  = 1'b1; tmp_q.push_back(e);
      if (oc == 4'b1111) begin
         for (int i = 0; i < 10; i++) begin
            e = blank(3'd4); e.halted = 1'b1; tmp_q.push_back(e);
         end
         return;
      end
      e = blank(3'd2);
      case (oc)
         4'b0001: begin e.rf_w_en = 1; e.alu_select = op[5] ? 3'd1 : 3'd0; end
         4'b0101: begin e.rf_w_en = 1; e.alu_select = op[5] ? 3'd3 : 3'd2; end
         4'b1001: begin e.rf_w_en = 1; e.alu_select = 3'd5; end
         4'b1110: begin e.rf_w_en = 1; e.alu_select = 3'd4; end
         4'b0010: begin e.rf_w_en = 1; e.mem_r = 3'd1; e.w_data = 2'd2; end
         4'b0110: begin e.rf_w_en = 1; e.mem_r = 3'd3; e.w_data = 2'd2; end
         4'b0011: begin e.mem_w_en = 1; e.r0 = 2'd1; end
         4'b0111: begin e.mem_w_en = 1; e.mem_w_addr = 2'd2; e.r0 = 2'd1; e.r1 = 2'd1; end
         4'b1010, 4'b1011: e.mem_r = 3'd1;
         4'b0100: begin
            e.rf_w_en = 1; e.w_addr = 2'd1; e.w_data = 2'd1;
            e.set_pc = op[11] ? 3'd2 : 3'd3;
         end
         4'b1100: e.set_pc = 3'd3;
         4'b0000: if ((op[11:9] & m_nzp) != 3'b000) e.set_pc = 3'd1;
         default: ;
      endcase
      tmp_q.push_back(e);
      if (oc inside {4'b0001, 4'b0101, 4'b1001, 4'b1110, 4'b0010, 4'b0110}) m_nzp = cc;
      if (oc == 4'b1010) begin
         e = blank(3'd3); e.rf_w_en = 1; e.mem_r = 3'd2; e.w_data = 2'd2;
         tmp_q.push_back(e);
         m_nzp = cc;
      end else if (oc == 4'b1011) begin
         e = blank(3'd3); e.mem_w_en = 1; e.mem_r = 3'd1; e.mem_w_addr = 2'd1; e.r0 = 2'd1;
         tmp_q.push_back(e);
      end
   endtask

   // Drives one instruction, checking at most lim of its cycles.
   task automatic run_instr(input logic [15:0] op, input logic [2:0] cc, input int lim);
      int k;
      opcode = op;
      condCode = cc;
      build(op, cc);
      k = (tmp_q.size() < lim) ? tmp_q.size() : lim;
      for (int i = 0; i < k; i++) exp_q.push_back(tmp_q[i]);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         obs[i] = act;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_strobes", 64'({load_ir, inc_pc, mem_w_en, rf_w_en, set_pc}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_nzp = 3'b010;
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      pulse_reset();
      chk("reset_nzp", 64'(nzp), 64'(3'b010));
      chk("reset_state", 64'(state_dbg), 64'd0);

      run_instr(16'h1042, 3'b100, 16);
      chk("add_c0_load_ir", 64'(obs[0].load_ir), 64'd1);
      chk("add_c1_inc_pc", 64'(obs[1].inc_pc), 64'd1);
      chk("add_c2_wen_alu", 64'({obs[2].rf_w_en, obs[2].alu_select}), 64'({1'b1, 3'd0}));
      chk("add_nzp_after", 64'(nzp), 64'(3'b100));
      chk("add_c3_state", 64'(state_dbg), 64'd0);

      run_instr(16'h1062, 3'b010, 16);
      run_instr(16'h0402, 3'b000, 16);
      chk("brz_taken", 64'(obs[2].set_pc), 64'd1);
      run_instr(16'h5021, 3'b001, 16);
      run_instr(16'h0402, 3'b000, 16);
      chk("brz_not_taken", 64'({obs[2].set_pc, obs[2].mem_w_en, obs[2].rf_w_en}), 64'd0);

      run_instr(16'h0005, 3'b000, 16);
      run_instr(16'h0E05, 3'b000, 16);
      run_instr(16'h903F, 3'b100, 16);
      run_instr(16'hE005, 3'b001, 16);
      run_instr(16'h2003, 3'b100, 16);
      run_instr(16'h6042, 3'b010, 16);
      run_instr(16'h3003, 3'b111, 16);
      run_instr(16'h7042, 3'b111, 16);
      run_instr(16'h1043, 3'b001, 16);
      run_instr(16'h5042, 3'b100, 16);
      run_instr(16'hC1C0, 3'b000, 16);
      run_instr(16'h8000, 3'b000, 16);
      run_instr(16'hD000, 3'b000, 16);

      run_instr(16'hA203, 3'b010, 16);
      chk("ldi_exec", 64'({obs[2].mem_r, obs[2].rf_w_en}), 64'({3'd1, 1'b0}));
      chk("ldi_exec2", 64'({obs[3].mem_r, obs[3].rf_w_en, obs[3].w_data}), 64'({3'd2, 1'b1, 2'd2}));

      run_instr(16'h4805, 3'b001, 16);
      chk("jsr_exec", 64'({obs[2].rf_w_en, obs[2].w_addr, obs[2].set_pc}), 64'({1'b1, 2'd1, 3'd2}));
      chk("jsr_nzp_kept", 64'(nzp), 64'(3'b010));
      run_instr(16'h4080, 3'b100, 16);
      run_instr(16'hB203, 3'b100, 16);

      run_instr(16'h1042, 3'b100, 16);
      run_instr(16'hB203, 3'b001, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("sti_rst_mem_w_en", 64'(mem_w_en), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_nzp = 3'b010;
      chk("sti_rst_state", 64'(state_dbg), 64'd0);
      chk("sti_rst_nzp", 64'(nzp), 64'(3'b010));

      run_instr(16'hF025, 3'b100, 16);
      chk("halt_c2", 64'(obs[2].halted), 64'd1);
      chk("halt_c11", 64'({obs[11].halted, obs[11].mem_w_en, obs[11].rf_w_en, obs[11].load_ir}),
          64'({1'b1, 3'b000}));
      pulse_reset();
      run_instr(16'h1042, 3'b001, 16);
      chk("post_halt_fetch", 64'(obs[0].load_ir), 64'd1);

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
